// File: rtl/ddr_axi_memtest.sv
// rtl/ddr_axi_memtest.sv - AXI4 write/read-back pattern memory tester for the DDR user port
// Optional error log enabled with `define DDR_MEMTEST_ERRLOG_EN.
module ddr_axi_memtest #(
  parameter int unsigned ID_WIDTH = 1,
  parameter int unsigned BEATS    = 8,
  parameter int unsigned TXN_ID   = 0
) (
  input  logic                user_clk,
  input  logic                user_rst,
  input  logic                i_start,
  input  logic [26:0]         i_base,
  input  logic [15:0]         i_nbursts,
  input  logic [31:0]         i_seed,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_pass,
  output logic [ID_WIDTH-1:0] o_awid,
  output logic [26:0]         o_awaddr,
  output logic [7:0]          o_awlen,
  output logic [3:0]          o_awsize,
  output logic [1:0]          o_awburst,
  output logic                o_awvalid,
  input  logic                i_awready,
  output logic [63:0]         o_wdata,
  output logic [7:0]          o_wstrb,
  output logic                o_wlast,
  output logic                o_wvalid,
  input  logic                i_wready,
  input  logic [ID_WIDTH-1:0] i_bid,
  input  logic [1:0]          i_bresp,
  input  logic                i_bvalid,
  output logic                o_bready,
  output logic [ID_WIDTH-1:0] o_arid,
  output logic [26:0]         o_araddr,
  output logic [7:0]          o_arlen,
  output logic [3:0]          o_arsize,
  output logic [1:0]          o_arburst,
  output logic                o_arvalid,
  input  logic                i_arready,
  input  logic [ID_WIDTH-1:0] i_rid,
  input  logic [63:0]         i_rdata,
  input  logic [1:0]          i_rresp,
  input  logic                i_rlast,
  input  logic                i_rvalid,
  output logic                o_rready
`ifdef DDR_MEMTEST_ERRLOG_EN
  ,
  output logic [15:0]         o_err_count,
  output logic [26:0]         o_err_addr
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_WA, S_WD, S_WB, S_RA, S_RD, S_DONE} state_t;

  localparam logic [ID_WIDTH-1:0] ID          = ID_WIDTH'(TXN_ID);
  localparam logic [7:0]          LAST_BEAT   = 8'(BEATS - 1);
  localparam logic [26:0]         BURST_BYTES = 27'(BEATS * 8);

  state_t      state, state_n;
  logic [26:0] base_q, burst_addr, beat_addr;
  logic [15:0] nbursts_q, burst_cnt;
  logic [31:0] seed_q;
  logic [7:0]  beat;
  logic        fail_q, done_q, pass_q;
  logic        last_beat, last_burst, b_err, r_err;
  logic [63:0] exp_data;
  logic        unused_base;

  assign unused_base = ^i_base[2:0];

  // Pattern is a pure function of the beat address, so write and read sides share it.
  assign beat_addr  = burst_addr + {16'b0, beat, 3'b000};
  assign exp_data   = {seed_q ^ {5'b0, beat_addr}, {5'b0, beat_addr}};
  assign last_beat  = (beat == LAST_BEAT);
  assign last_burst = (burst_cnt == 16'(nbursts_q - 16'd1));
  assign b_err      = (i_bresp != 2'b00) || (i_bid != ID);
  assign r_err      = (i_rdata != exp_data) || (i_rresp != 2'b00) || (i_rid != ID) ||
                      (i_rlast != last_beat);

  assign o_awid    = ID;
  assign o_awaddr  = burst_addr;
  assign o_awlen   = LAST_BEAT;
  assign o_awsize  = 4'd3;
  assign o_awburst = 2'b01;
  assign o_wdata   = exp_data;
  assign o_wstrb   = 8'hFF;
  assign o_wlast   = (state == S_WD) && last_beat;
  assign o_arid    = ID;
  assign o_araddr  = burst_addr;
  assign o_arlen   = LAST_BEAT;
  assign o_arsize  = 4'd3;
  assign o_arburst = 2'b01;
  assign o_busy    = (state != S_IDLE) && (state != S_DONE);
  assign o_done    = done_q;
  assign o_pass    = pass_q;

  always_comb begin
    state_n   = state;
    o_awvalid = 1'b0;
    o_wvalid  = 1'b0;
    o_bready  = 1'b0;
    o_arvalid = 1'b0;
    o_rready  = 1'b0;
    case (state)
      S_IDLE: if (i_start) state_n = (i_nbursts == 16'd0) ? S_DONE : S_WA;
      S_WA: begin
        o_awvalid = 1'b1;
        if (i_awready) state_n = S_WD;
      end
      S_WD: begin
        o_wvalid = 1'b1;
        if (i_wready && last_beat) state_n = S_WB;
      end
      S_WB: begin
        o_bready = 1'b1;
        if (i_bvalid) state_n = last_burst ? S_RA : S_WA;
      end
      S_RA: begin
        o_arvalid = 1'b1;
        if (i_arready) state_n = S_RD;
      end
      S_RD: begin
        o_rready = 1'b1;
        if (i_rvalid && last_beat) state_n = last_burst ? S_DONE : S_RA;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state      <= S_IDLE;
      base_q     <= '0;
      nbursts_q  <= '0;
      seed_q     <= '0;
      burst_addr <= '0;
      burst_cnt  <= '0;
      beat       <= '0;
      fail_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE: if (i_start) begin
          base_q     <= {i_base[26:3], 3'b000};
          burst_addr <= {i_base[26:3], 3'b000};
          nbursts_q  <= i_nbursts;
          seed_q     <= i_seed;
          burst_cnt  <= '0;
          beat       <= '0;
          fail_q     <= 1'b0;
          done_q     <= (i_nbursts == 16'd0);
          pass_q     <= (i_nbursts == 16'd0);
        end
        S_WD: if (i_wready) beat <= last_beat ? 8'd0 : beat + 8'd1;
        S_WB: if (i_bvalid) begin
          if (b_err) fail_q <= 1'b1;
          if (last_burst) begin
            burst_cnt  <= '0;
            burst_addr <= base_q;
          end else begin
            burst_cnt  <= burst_cnt + 16'd1;
            burst_addr <= burst_addr + BURST_BYTES;
          end
        end
        S_RD: if (i_rvalid) begin
          if (r_err) fail_q <= 1'b1;
          beat <= last_beat ? 8'd0 : beat + 8'd1;
          if (last_beat) begin
            if (last_burst) begin
              done_q <= 1'b1;
              pass_q <= !(fail_q || r_err);
            end else begin
              burst_cnt  <= burst_cnt + 16'd1;
              burst_addr <= burst_addr + BURST_BYTES;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DDR_MEMTEST_ERRLOG_EN
  logic        log_ev;
  logic [26:0] log_addr;

  assign log_ev   = ((state == S_WB) && i_bvalid && b_err) || ((state == S_RD) && i_rvalid && r_err);
  assign log_addr = (state == S_WB) ? burst_addr : beat_addr;

  always_ff @(posedge user_clk) begin
    if (user_rst || ((state == S_IDLE) && i_start)) begin
      o_err_count <= '0;
      o_err_addr  <= '0;
    end else if (log_ev) begin
      if (o_err_count != 16'hFFFF) o_err_count <= o_err_count + 16'd1;
      if (o_err_count == 16'd0) o_err_addr <= log_addr;
    end
  end
`endif

endmodule

// File: tb/tb_ddr_axi_memtest.sv
// tb/tb_ddr_axi_memtest.sv - self-checking bench for ddr_axi_memtest with a randomized AXI slave
module tb_ddr_axi_memtest;
  localparam int BEATS = 8;

  logic        clk = 1'b0;
  logic        user_rst, i_start;
  logic [26:0] i_base;
  logic [15:0] i_nbursts;
  logic [31:0] i_seed;
  logic        busy, done, pass;
  logic [0:0]  awid, bid, arid, rid;
  logic [26:0] awaddr, araddr;
  logic [7:0]  awlen, arlen, wstrb;
  logic [3:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic [63:0] wdata, rdata;
`ifdef DDR_MEMTEST_ERRLOG_EN
  logic [15:0] err_count;
  logic [26:0] err_addr;
`endif

  always #5 clk = ~clk;

  ddr_axi_memtest #(.ID_WIDTH(1), .BEATS(BEATS), .TXN_ID(0)) dut (
    .user_clk(clk), .user_rst(user_rst), .i_start(i_start), .i_base(i_base),
    .i_nbursts(i_nbursts), .i_seed(i_seed), .o_busy(busy), .o_done(done), .o_pass(pass),
    .o_awid(awid), .o_awaddr(awaddr), .o_awlen(awlen), .o_awsize(awsize),
    .o_awburst(awburst), .o_awvalid(awvalid), .i_awready(awready),
    .o_wdata(wdata), .o_wstrb(wstrb), .o_wlast(wlast), .o_wvalid(wvalid), .i_wready(wready),
    .i_bid(bid), .i_bresp(bresp), .i_bvalid(bvalid), .o_bready(bready),
    .o_arid(arid), .o_araddr(araddr), .o_arlen(arlen), .o_arsize(arsize),
    .o_arburst(arburst), .o_arvalid(arvalid), .i_arready(arready),
    .i_rid(rid), .i_rdata(rdata), .i_rresp(rresp), .i_rlast(rlast), .i_rvalid(rvalid),
    .o_rready(rready)
`ifdef DDR_MEMTEST_ERRLOG_EN
    , .o_err_count(err_count), .o_err_addr(err_addr)
`endif
  );

  int n_pass = 0, n_fail = 0, n_total = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: pattern and address rules straight from the data-path definition.
  function automatic logic [63:0] pat(input logic [31:0] seed, input logic [26:0] a);
    return {seed ^ {5'b0, a}, {5'b0, a}};
  endfunction

  logic [26:0] t_base;
  logic [31:0] t_seed;
  bit          stall_en;
  int          flip_burst = -1, flip_beat = 0, bad_burst = -1;

  function automatic logic [26:0] waddr(input int n);
    return 27'(t_base + 27'(n * 8));
  endfunction

  // Slave bookkeeping
  logic [63:0] mem [logic [26:0]];
  logic [26:0] aw_log [$];
  int aw_cnt, w_cnt, b_pend, b_cnt, ar_cnt, r_pend, r_burst, r_beat, traffic, last_r_cyc;
  logic [63:0] first_wdata;
  bit aw_st, w_st, ar_st;
  logic [26:0] aw_prev, ar_prev;
  logic [64:0] w_prev;
  logic n_awready, n_wready, n_arready, n_bvalid, n_rvalid, n_rlast;
  logic [1:0]  n_bresp;
  logic [63:0] n_rdata;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic rnd_go();
    return !stall_en || ($urandom_range(0, 3) == 0);
  endfunction

  initial begin
    awready = 0; wready = 0; arready = 0; bvalid = 0; bid = 0; bresp = 0;
    rvalid = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0;
    n_awready = 0; n_wready = 0; n_arready = 0; n_bvalid = 0; n_rvalid = 0; n_rlast = 0;
    n_bresp = 0; n_rdata = 0;
    forever begin
      @(negedge clk);
      if (user_rst) begin
        b_pend = 0; r_pend = 0; r_beat = 0; aw_st = 0; w_st = 0; ar_st = 0;
        n_awready = 0; n_wready = 0; n_arready = 0; n_bvalid = 0; n_rvalid = 0;
      end else begin
        if (awvalid || wvalid || arvalid) traffic++;
        if (aw_st) check("aw_stable", {awvalid, awaddr}, {1'b1, aw_prev});
        if (w_st)  check("w_stable", {wvalid, wlast, wdata}, {1'b1, w_prev});
        if (ar_st) check("ar_stable", {arvalid, araddr}, {1'b1, ar_prev});
        aw_st = awvalid && !awready; aw_prev = awaddr;
        w_st  = wvalid && !wready;   w_prev  = {wlast, wdata};
        ar_st = arvalid && !arready; ar_prev = araddr;
        if (wvalid && wready) begin
          check("w_after_aw", w_cnt < aw_cnt * BEATS, 1'b1);
          check("wdata", wdata, pat(t_seed, waddr(w_cnt)));
          check("wlast_wstrb", {wlast, wstrb}, {(w_cnt % BEATS) == BEATS - 1, 8'hFF});
          if (w_cnt == 0) first_wdata = wdata;
          mem[waddr(w_cnt)] = wdata;
          w_cnt++;
          if (w_cnt % BEATS == 0) b_pend++;
        end
        if (awvalid && awready) begin
          check("awaddr", awaddr, 27'(t_base + 27'(aw_cnt * BEATS * 8)));
          check("aw_fields", {awid, awlen, awsize, awburst}, {1'b0, 8'(BEATS - 1), 4'd3, 2'd1});
          aw_log.push_back(awaddr);
          aw_cnt++;
        end
        if (bvalid && bready) begin b_pend--; b_cnt++; end
        if (arvalid && arready) begin
          check("araddr", araddr, 27'(t_base + 27'(ar_cnt * BEATS * 8)));
          check("ar_fields", {arid, arlen, arsize, arburst}, {1'b0, 8'(BEATS - 1), 4'd3, 2'd1});
          ar_cnt++; r_pend++;
        end
        if (rvalid && rready) begin
          if (rlast) last_r_cyc = cyc + 1;
          r_beat++;
          if (r_beat == BEATS) begin r_beat = 0; r_burst++; r_pend--; end
        end
        n_awready = rnd_go(); n_wready = rnd_go(); n_arready = rnd_go();
        if (!(bvalid && !bready)) begin
          n_bvalid = (b_pend > 0) && rnd_go();
          n_bresp  = (b_cnt == bad_burst) ? 2'b10 : 2'b00;
        end
        if (!(rvalid && !rready)) begin
          n_rvalid = (r_pend > 0) && rnd_go();
          n_rdata  = mem.exists(waddr(r_burst * BEATS + r_beat)) ? mem[waddr(r_burst * BEATS + r_beat)] : 64'd0;
          if (r_burst == flip_burst && r_beat == flip_beat) n_rdata[0] = ~n_rdata[0];
          n_rlast  = (r_beat == BEATS - 1);
        end
      end
      @(posedge clk); #1;
      awready = n_awready; wready = n_wready; arready = n_arready;
      bvalid = n_bvalid; bresp = n_bresp;
      rvalid = n_rvalid; rdata = n_rdata; rlast = n_rlast;
    end
  end

  task automatic arm(input logic [26:0] base, input int nb, input logic [31:0] seed,
                     input bit stall, input int flip_b, input int flip_bt, input int bad_b);
    t_base = {base[26:3], 3'b000}; t_seed = seed; stall_en = stall;
    flip_burst = flip_b; flip_beat = flip_bt; bad_burst = bad_b;
    aw_cnt = 0; w_cnt = 0; b_pend = 0; b_cnt = 0; ar_cnt = 0; r_pend = 0; r_burst = 0;
    r_beat = 0; traffic = 0; last_r_cyc = -1; aw_log.delete(); mem.delete();
    i_base = base; i_nbursts = 16'(nb); i_seed = seed; i_start = 1;
    @(posedge clk); #1;
    i_start = 0;
  endtask

  task automatic run(input logic [26:0] base, input int nb, input logic [31:0] seed,
                     input bit stall, input int flip_b, input int flip_bt, input int bad_b,
                     input bit poke);
    int start_cyc, done_cyc;
    bit poked, exp_pass;
    exp_pass = !((flip_b >= 0 && flip_b < nb) || (bad_b >= 0 && bad_b < nb));
    arm(base, nb, seed, stall, flip_b, flip_bt, bad_b);
    start_cyc = cyc;
    if (nb > 0) check("aw_latency", {awvalid, busy, done}, 3'b110);
    poked = 0; done_cyc = -1;
    for (int i = 0; i < 6000; i++) begin
      if (done) begin done_cyc = cyc; break; end
      if (poke && rready && !poked) begin i_nbursts = 16'd5; i_start = 1; poked = 1; end
      else i_start = 0;
      @(posedge clk); #1;
    end
    i_start = 0;
    check("done_seen", done_cyc >= 0, 1'b1);
    check("pass", pass, exp_pass);
    check("busy_at_done", busy, 1'b0);
    check("txn_counts", {16'(aw_cnt), 16'(w_cnt), 16'(ar_cnt)}, {16'(nb), 16'(nb * BEATS), 16'(nb)});
    if (nb > 0) check("done_latency", done_cyc, last_r_cyc);
    else check("done_latency0", {done_cyc, traffic}, {start_cyc, 32'd0});
    if (poke) check("poked", poked, 1'b1);
    @(posedge clk); #1;
    check("done_sticky", {done, pass}, {1'b1, exp_pass});
  endtask

  initial begin
    user_rst = 1; i_start = 0; i_base = 0; i_nbursts = 0; i_seed = 0; stall_en = 0;
    t_base = 0; t_seed = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {awvalid, wvalid, arvalid, bready, rready, busy, done, pass}, 8'h00);
    user_rst = 0;
    @(posedge clk); #1;

    run(27'h100, 2, 32'hA5A5A5A5, 0, -1, 0, -1, 0);
    check("beat0_wdata", first_wdata, 64'hA5A5A4A5_00000100);
    check("aw_list", {aw_log[0], aw_log[1]}, {27'h100, 27'h140});

    run(27'h100, 2, 32'hA5A5A5A5, 0, 1, 3, -1, 0);
`ifdef DDR_MEMTEST_ERRLOG_EN
    check("errlog_flip", {err_count, err_addr}, {16'd1, 27'h158});
`endif

    for (int k = 0; k < 3; k++)
      run(27'($urandom), int'($urandom_range(1, 5)), $urandom, 1, -1, 0, -1, 0);

    run(27'h7FFFFC0, 2, $urandom, 1, -1, 0, -1, 0);
    check("wrap_addr", aw_log[1], 27'h0);
    run(27'h123, 0, 32'h1, 0, -1, 0, -1, 0);

    run(27'h2000, 2, 32'h0F0F0F0F, 1, -1, 0, 0, 1);
`ifdef DDR_MEMTEST_ERRLOG_EN
    check("errlog_bresp", {err_count, err_addr}, {16'd1, 27'h2000});
`endif

    arm(27'h400, 3, 32'h5555AAAA, 1, -1, 0, -1);
    for (int i = 0; i < 200 && !wvalid; i++) begin @(posedge clk); #1; end
    check("reached_wd", wvalid, 1'b1);
    user_rst = 1;
    @(posedge clk); #1;
    check("mid_reset", {awvalid, wvalid, arvalid, busy, done}, 5'b0);
    user_rst = 0;
    @(posedge clk); #1;
    run(27'h400, 3, 32'h5555AAAA, 1, -1, 0, -1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
